sequence_detector_param: RTL and testbench
==========================================

// Module: sequence_detector_param
// PURPOSE
//   Parametrised serial pattern detector, successor to the fixed 3-state "11" Moore detector.
//   Matches a run-time-loadable PATTERN_LEN-bit pattern on serial input w, one bit per enabled clock.
//   Selectable overlapping / non-overlapping detection, with a saturating match counter.
//   Sits between a serial front end (UART/line decoder) and control logic that consumes z or match_cnt.
// PARAMETERS
//   PATTERN_LEN  3      pattern length in bits, >= 2
//   OVERLAP      1      1: bits of a completed match can start the next match; 0: history restarts after each match
//   CNT_W        8      match counter width, saturating
//   RST_PATTERN  3'b011 pattern in effect after reset; width PATTERN_LEN, MSB is the first bit received
// PORTS
//   clk          in   1            system clock, rising edge
//   rst          in   1            asynchronous, active-high reset
//   w            in   1            serial data bit, sampled on rising clk when en=1
//   en           in   1            sample enable; en=0 holds all state
//   pattern_in   in   PATTERN_LEN  new pattern, MSB = first bit in time
//   pattern_ld   in   1            1-cycle strobe: latch pattern_in and clear history
//   clr_cnt      in   1            synchronous clear of match_cnt
//   z            out  1            Moore match flag: 1 while the last PATTERN_LEN samples equal the pattern
//   match_cnt    out  CNT_W        number of matches since reset or clr_cnt, saturates at all-ones
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-high.
//   - rst=1 forces: pattern_reg=RST_PATTERN, hist=0, fill=0, match_cnt=0. Hence z=0 with no clock.
//   - State registers:
//     - hist[PATTERN_LEN-1:0]: shift register, newest bit in LSB.
//     - fill: count of valid bits, 0..PATTERN_LEN.
//     - pattern_reg and match_cnt.
//   - z = (fill==PATTERN_LEN) && (hist==pattern_reg).
//     - Decoded from registers only; no combinational path from w.
//     - z asserts in the cycle after the rising edge that samples the last pattern bit.
//   - Sampling edge (en=1, pattern_ld=0):
//     - Normal case: hist <= {hist[PATTERN_LEN-2:0], w}; fill <= min(fill+1, PATTERN_LEN).
//     - OVERLAP=0 and z=1 at that edge: hist <= {0..., w}; fill <= 1 (the matched bits are consumed).
//     - "new_match" = next-state hist/fill satisfy the z equation.
//   - match_cnt:
//     - Increments on every edge where new_match=1, including back-to-back matches in overlap mode.
//     - Holds at 2^CNT_W-1 once reached.
//     - en=0 freezes z high; it is never counted twice.
//   - pattern_ld=1: pattern_reg <= pattern_in, hist <= 0, fill <= 0.
//     - The w sample in that cycle is discarded, even if en=1.
//     - match_cnt is unaffected.
//   - clr_cnt=1: match_cnt <= 0. If it coincides with new_match, the clear wins (result 0).
//   - en=0: hist, fill and match_cnt hold; z holds its value.
//   - Reset mid-stream discards partial history; detection restarts from fill=0 once rst drops.
//   - A pattern of all zeros must not match before fill reaches PATTERN_LEN (handled via fill).
//   - Latency: the sampling edge of the final bit determines z for the next cycle; match_cnt updates on that same edge.
// TESTING
//   Defaults PATTERN_LEN=3, CNT_W=8 unless stated. Each bit below is one enabled clock.
//   1. Reset check, OVERLAP=1, pattern_ld 3'b111:
//      - rst high -> z=0, match_cnt=0 asynchronously.
//      - w=0,0,1,0,1,1,0,1,1,1,0 -> z high for exactly 1 cycle (after the 10th bit); match_cnt=1.
//   2. Overlap, pattern 3'b111:
//      - w=1,1,1,1,1 -> z high after bits 3, 4 and 5; match_cnt=3.
//   3. Non-overlap (OVERLAP=0), pattern 3'b111:
//      - w=1,1,1,1,1,1 -> z high after bits 3 and 6 only; match_cnt=2.
//   4. Pattern 3'b101:
//      - OVERLAP=1: w=1,0,1,0,1 -> match_cnt=2.
//      - OVERLAP=0: same stream -> match_cnt=1.
//   5. Counter edge cases, CNT_W=2, pattern 3'b111, OVERLAP=1:
//      - Six 1s -> match_cnt saturates at 3.
//      - clr_cnt on the same edge as a new match -> match_cnt=0.
//      - en=0 for 5 cycles while z=1 -> z stays 1, match_cnt unchanged.
//   6. Mid-stream reconfiguration, pattern 3'b110:
//      - After w=1,1 (fill=2), pattern_ld with 3'b011 and en=1, w=1 -> sample dropped, fill=0.
//      - Then w=0,1,1 -> z=1, match_cnt=1.
//      - Separately, async rst pulse mid-sequence -> z=0 immediately, with no spurious match after release.

Source files
------------

// File: rtl/sequence_detector_param.sv
// Serial pattern detector with a run-time loadable pattern, selectable overlap
// handling and a saturating match counter. The match flag z is decoded only from registered state.
module sequence_detector_param #(
    parameter int                     PATTERN_LEN = 3,
    parameter int                     OVERLAP     = 1,
    parameter int                     CNT_W       = 8,
    parameter logic [PATTERN_LEN-1:0] RST_PATTERN = 3'b011
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   w,
    input  logic                   en,
    input  logic [PATTERN_LEN-1:0] pattern_in,
    input  logic                   pattern_ld,
    input  logic                   clr_cnt,
    output logic                   z,
    output logic [CNT_W-1:0]       match_cnt
);

    localparam int                     FILL_W    = $clog2(PATTERN_LEN + 1);
    localparam logic [FILL_W-1:0]      FILL_FULL = FILL_W'(PATTERN_LEN);
    localparam logic [FILL_W-1:0]      FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0]      FILL_ZERO = {FILL_W{1'b0}};
    localparam logic [CNT_W-1:0]       CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]       CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [PATTERN_LEN-1:0] HIST_ZERO = {PATTERN_LEN{1'b0}};

    logic [PATTERN_LEN-1:0] pattern_q, pattern_d;
    logic [PATTERN_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]       match_cnt_q, match_cnt_d;
    logic                   z_q, z_d;
    logic                   new_match_s;

    // Next-state for pattern, history, fill level, match flag and counter
    always_comb begin
        pattern_d   = pattern_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        match_cnt_d = match_cnt_q;
        new_match_s = 1'b0;

        if (pattern_ld) begin
            pattern_d = pattern_in;
            hist_d    = HIST_ZERO;
            fill_d    = FILL_ZERO;
        end else if (en) begin
            // Without overlap a completed match is consumed: only the new bit survives.
            if ((OVERLAP == 0) && z_q) begin
                hist_d = {{(PATTERN_LEN-1){1'b0}}, w};
                fill_d = FILL_ONE;
            end else begin
                hist_d = {hist_q[PATTERN_LEN-2:0], w};
                fill_d = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_ONE;
            end
            new_match_s = (fill_d == FILL_FULL) && (hist_d == pattern_d);
        end else begin
            hist_d = hist_q;
        end

        z_d = (fill_d == FILL_FULL) && (hist_d == pattern_d);

        if (clr_cnt) begin
            match_cnt_d = CNT_ZERO;
        end else if (new_match_s && (match_cnt_q != CNT_MAX)) begin
            match_cnt_d = match_cnt_q + CNT_ONE;
        end else begin
            match_cnt_d = match_cnt_q;
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q   <= RST_PATTERN;
            hist_q      <= HIST_ZERO;
            fill_q      <= FILL_ZERO;
            match_cnt_q <= CNT_ZERO;
            z_q         <= 1'b0;
        end else begin
            pattern_q   <= pattern_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_cnt_q <= match_cnt_d;
            z_q         <= z_d;
        end
    end

    assign z         = z_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_sequence_detector_param.sv
// Directed bench: three detector instances (overlap, non-overlap, 2-bit counter)
// share one stimulus stream and are checked against hand-computed values.
module tb_sequence_detector_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w = 1'b0;
    logic       en = 1'b0;
    logic       pattern_ld = 1'b0;
    logic       clr_cnt = 1'b0;
    logic [2:0] pattern_in = 3'b000;

    logic       z_ov, z_no, z_c2;
    logic [7:0] cnt_ov, cnt_no;
    logic [1:0] cnt_c2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sequence_detector_param #(.PATTERN_LEN(3), .OVERLAP(1), .CNT_W(8), .RST_PATTERN(3'b011)) u_ov (
        .clk(clk), .rst(rst), .w(w), .en(en), .pattern_in(pattern_in),
        .pattern_ld(pattern_ld), .clr_cnt(clr_cnt), .z(z_ov), .match_cnt(cnt_ov));

    sequence_detector_param #(.PATTERN_LEN(3), .OVERLAP(0), .CNT_W(8), .RST_PATTERN(3'b011)) u_no (
        .clk(clk), .rst(rst), .w(w), .en(en), .pattern_in(pattern_in),
        .pattern_ld(pattern_ld), .clr_cnt(clr_cnt), .z(z_no), .match_cnt(cnt_no));

    sequence_detector_param #(.PATTERN_LEN(3), .OVERLAP(1), .CNT_W(2), .RST_PATTERN(3'b011)) u_c2 (
        .clk(clk), .rst(rst), .w(w), .en(en), .pattern_in(pattern_in),
        .pattern_ld(pattern_ld), .clr_cnt(clr_cnt), .z(z_c2), .match_cnt(cnt_c2));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One enabled sample, then check both overlap variants' z
    task automatic send(input logic wv, input logic ez_ov, input logic ez_no, input string tag);
        en = 1'b1;
        w  = wv;
        tick();
        en = 1'b0;
        chk({tag, "_z_ov"}, {31'd0, z_ov}, {31'd0, ez_ov});
        chk({tag, "_z_no"}, {31'd0, z_no}, {31'd0, ez_no});
    endtask

    task automatic load(input logic [2:0] p, input logic clr);
        pattern_in = p;
        pattern_ld = 1'b1;
        clr_cnt    = clr;
        en         = 1'b0;
        tick();
        pattern_ld = 1'b0;
        clr_cnt    = 1'b0;
    endtask

    initial begin
        logic [10:0] v11;
        logic [5:0]  v6;
        logic [4:0]  v5;

        // Asynchronous reset, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_z", {31'd0, z_ov}, 32'd0);
        chk("rst_cnt", {24'd0, cnt_ov}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Test 1: single embedded 111 match
        load(3'b111, 1'b1);
        v11 = 11'b001_0110_1110;
        for (int i = 10; i >= 0; i--) send(v11[i], i == 1, i == 1, $sformatf("t1_b%0d", 11 - i));
        chk("t1_cnt_ov", {24'd0, cnt_ov}, 32'd1);
        chk("t1_cnt_no", {24'd0, cnt_no}, 32'd1);

        // Tests 2, 3 and counter saturation: run of ones
        load(3'b111, 1'b1);
        v6 = 6'b001111;
        for (int i = 1; i <= 5; i++) send(1'b1, i >= 3, (i == 3), $sformatf("t2_b%0d", i));
        chk("t2_cnt_ov", {24'd0, cnt_ov}, 32'd3);
        send(1'b1, 1'b1, 1'b1, "t3_b6");
        chk("t3_cnt_no", {24'd0, cnt_no}, 32'd2);
        chk("t5_sat_c2", {30'd0, cnt_c2}, 32'd3);
        chk("t2_cnt_ov6", {24'd0, cnt_ov}, 32'd4);
        chk("t5_v6_unused", {26'd0, v6}, 32'd15);

        // Enable low: z held high, counters frozen
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t5_hold_z_%0d", i), {31'd0, z_c2}, 32'd1);
            chk($sformatf("t5_hold_cnt_%0d", i), {24'd0, cnt_ov}, 32'd4);
        end
        chk("t5_hold_c2", {30'd0, cnt_c2}, 32'd3);

        // Clear coinciding with a new match wins
        clr_cnt = 1'b1;
        send(1'b1, 1'b1, 1'b0, "t5_clr");
        clr_cnt = 1'b0;
        chk("t5_clr_ov", {24'd0, cnt_ov}, 32'd0);
        chk("t5_clr_c2", {30'd0, cnt_c2}, 32'd0);
        send(1'b1, 1'b1, 1'b0, "t5_after");
        chk("t5_after_ov", {24'd0, cnt_ov}, 32'd1);

        // Test 4: pattern 101
        load(3'b101, 1'b1);
        v5 = 5'b10101;
        for (int i = 4; i >= 0; i--) send(v5[i], (i == 2) || (i == 0), i == 2, $sformatf("t4_b%0d", 5 - i));
        chk("t4_cnt_ov", {24'd0, cnt_ov}, 32'd2);
        chk("t4_cnt_no", {24'd0, cnt_no}, 32'd1);

        // Test 6: reload mid-stream drops the coincident sample
        load(3'b110, 1'b1);
        send(1'b1, 1'b0, 1'b0, "t6_a1");
        send(1'b1, 1'b0, 1'b0, "t6_a2");
        pattern_in = 3'b011;
        pattern_ld = 1'b1;
        send(1'b1, 1'b0, 1'b0, "t6_ld");
        pattern_ld = 1'b0;
        send(1'b0, 1'b0, 1'b0, "t6_b1");
        send(1'b1, 1'b0, 1'b0, "t6_b2");
        send(1'b1, 1'b1, 1'b1, "t6_b3");
        chk("t6_cnt_ov", {24'd0, cnt_ov}, 32'd1);

        // A dropped 0 must not complete 011 with the next two ones
        pattern_ld = 1'b1;
        send(1'b0, 1'b0, 1'b0, "t6_ld2");
        pattern_ld = 1'b0;
        send(1'b1, 1'b0, 1'b0, "t6_c1");
        send(1'b1, 1'b0, 1'b0, "t6_c2");

        // Async reset while z is high
        load(3'b011, 1'b1);
        send(1'b0, 1'b0, 1'b0, "t6_d1");
        send(1'b1, 1'b0, 1'b0, "t6_d2");
        send(1'b1, 1'b1, 1'b1, "t6_d3");
        rst = 1'b1;
        #2;
        chk("t6_rst_z", {31'd0, z_ov}, 32'd0);
        chk("t6_rst_cnt", {24'd0, cnt_ov}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Partial history 0,1 then reset: next 1 must not complete 011
        send(1'b0, 1'b0, 1'b0, "t6_e1");
        send(1'b1, 1'b0, 1'b0, "t6_e2");
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
        send(1'b1, 1'b0, 1'b0, "t6_f1");
        send(1'b1, 1'b0, 1'b0, "t6_f2");
        send(1'b0, 1'b0, 1'b0, "t6_f3");
        send(1'b1, 1'b0, 1'b0, "t6_f4");
        send(1'b1, 1'b1, 1'b1, "t6_f5");
        chk("t6_post_cnt", {24'd0, cnt_ov}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
